// File: rtl/clock_display_scan.sv
// clock_display_scan: six-digit common-anode 7-segment scanner for an HH.MM.SS
// time display. Each field is snapshotted once per scan frame so a frame never
// mixes values from both sides of a counter rollover.
// Optional build macro: CLOCK_DISPLAY_HOUR12_EN selects a 12-hour display with a
// PM indicator on the leftmost decimal point; the default is a 24-hour display.
//
// Digit index | shows
// 0           | sec ones (rightmost)
// 1           | sec tens
// 2           | min ones (dp lit)
// 3           | min tens
// 4           | hour ones (dp lit)
// 5           | hour tens (dp = PM in 12-hour build)
module clock_display_scan #(
  parameter int SCAN_DIV = 50000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [5:0] sec,
  input  logic [5:0] min,
  input  logic [4:0] hour,
  output logic [5:0] an,
  output logic [6:0] seg,
  output logic       dp,
  output logic       frame_tick
);

  localparam int PW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam logic [PW-1:0] LAST = PW'(SCAN_DIV - 1);
  localparam logic [6:0] DASH = 7'b0111111;

  logic [PW-1:0] prescaler;
  logic [2:0]    index;
  logic [5:0]    snap_sec;
  logic [5:0]    snap_min;
  logic [4:0]    snap_hour;

  logic          step;
  logic          wrap;
  logic [2:0]    index_n;
  logic [5:0]    cur_sec;
  logic [5:0]    cur_min;
  logic [4:0]    cur_hour;
  logic [5:0]    hour_disp;
  logic          pm;
  logic          sec_ok;
  logic          min_ok;
  logic          hour_ok;
  logic [11:0]   sec_bcd;
  logic [11:0]   min_bcd;
  logic [11:0]   hour_bcd;
  logic [5:0]    digit;
  logic          digit_ok;
  logic [5:0]    an_n;
  logic [6:0]    seg_n;
  logic          dp_n;

  // Split a 0..63 value into {tens, ones} by repeated compare/subtract of ten.
  function automatic logic [11:0] to_bcd(input logic [5:0] v);
    logic [5:0] r;
    logic [5:0] t;
    r = v;
    t = 6'd0;
    for (int i = 0; i < 6; i++) begin
      if (r >= 6'd10) begin
        r = r - 6'd10;
        t = t + 6'd1;
      end
    end
    return {t, r};
  endfunction

  // Active-low gfedcba pattern for one decimal digit; anything else is a dash.
  function automatic logic [6:0] seg_code(input logic [5:0] d);
    case (d)
      6'd0:    return 7'b1000000;
      6'd1:    return 7'b1111001;
      6'd2:    return 7'b0100100;
      6'd3:    return 7'b0110000;
      6'd4:    return 7'b0011001;
      6'd5:    return 7'b0010010;
      6'd6:    return 7'b0000010;
      6'd7:    return 7'b1111000;
      6'd8:    return 7'b0000000;
      6'd9:    return 7'b0010000;
      default: return DASH;
    endcase
  endfunction

  assign step    = (prescaler == LAST);
  assign wrap    = step && (index == 3'd5);
  assign index_n = (index == 3'd5) ? 3'd0 : index + 3'd1;

  // On a frame start the outputs must already use the values being captured.
  assign cur_sec  = wrap ? sec  : snap_sec;
  assign cur_min  = wrap ? min  : snap_min;
  assign cur_hour = wrap ? hour : snap_hour;

  // Decode the digit that becomes visible at the next step.
  always_comb begin
    sec_ok    = (cur_sec <= 6'd59);
    min_ok    = (cur_min <= 6'd59);
    hour_ok   = (cur_hour <= 5'd23);
    hour_disp = {1'b0, cur_hour};
    pm        = 1'b0;
`ifdef CLOCK_DISPLAY_HOUR12_EN
    if (cur_hour == 5'd0) begin
      hour_disp = 6'd12;
    end else if (cur_hour > 5'd12) begin
      hour_disp = {1'b0, cur_hour} - 6'd12;
    end
    pm = hour_ok && (cur_hour >= 5'd12);
`endif
    sec_bcd  = to_bcd(cur_sec);
    min_bcd  = to_bcd(cur_min);
    hour_bcd = to_bcd(hour_disp);
    digit    = 6'd0;
    digit_ok = 1'b0;
    dp_n     = 1'b1;
    case (index_n)
      3'd0: begin digit = sec_bcd[5:0];   digit_ok = sec_ok;  end
      3'd1: begin digit = sec_bcd[11:6];  digit_ok = sec_ok;  end
      3'd2: begin digit = min_bcd[5:0];   digit_ok = min_ok;  dp_n = 1'b0; end
      3'd3: begin digit = min_bcd[11:6];  digit_ok = min_ok;  end
      3'd4: begin digit = hour_bcd[5:0];  digit_ok = hour_ok; dp_n = 1'b0; end
      3'd5: begin digit = hour_bcd[11:6]; digit_ok = hour_ok; dp_n = ~pm; end
      default: begin digit = 6'd0; digit_ok = 1'b0; end
    endcase
    seg_n = digit_ok ? seg_code(digit) : DASH;
    an_n  = ~(6'b000001 << index_n);
  end

  // Prescaler: counts 0..SCAN_DIV-1 and wraps, one step per digit slot.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      prescaler <= '0;
    end else if (step) begin
      prescaler <= '0;
    end else begin
      prescaler <= prescaler + 1'b1;
    end
  end

  // Digit index and per-frame snapshot of the time fields.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      index     <= 3'd5;
      snap_sec  <= '0;
      snap_min  <= '0;
      snap_hour <= '0;
    end else if (step) begin
      index <= index_n;
      if (wrap) begin
        snap_sec  <= sec;
        snap_min  <= min;
        snap_hour <= hour;
      end
    end
  end

  // Registered display outputs, changing together with the digit index.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      an         <= 6'b111111;
      seg        <= 7'b1111111;
      dp         <= 1'b1;
      frame_tick <= 1'b0;
    end else begin
      frame_tick <= wrap;
      if (step) begin
        an  <= an_n;
        seg <= seg_n;
        dp  <= dp_n;
      end
    end
  end

endmodule

// File: doc/clock_display_scan.md
Name: clock_display_scan

Overview:
- Downstream consumer of the time-of-day counter.
- Takes binary sec/min/hour and converts each field to two BCD digits.
- Time-multiplexes six common-anode 7-segment digits, shown as HH.MM.SS.
- Snapshots the time once per scan frame, so a displayed frame never mixes values across a counter rollover.

Parameters:
- SCAN_DIV, 50000: clock cycles each digit stays lit. Legal range ≥2.

Ports:
- clock  input  1  system clock
- reset  input  1  asynchronous, active-high reset
- sec  input  6  seconds, binary, legal 0..59
- min  input  6  minutes, binary, legal 0..59
- hour  input  5  hours, binary, legal 0..23
- an  output  6  digit enables, active-low, one-hot-zero; an[0] = rightmost digit (sec ones)
- seg  output  7  segments, active-low, bit order {g,f,e,d,c,b,a}
- dp  output  1  decimal point, active-low
- frame_tick  output  1  one-cycle pulse when a new frame starts (snapshot taken)

Behaviour:
- Reset (asynchronous, active-high):
  - prescaler = 0, digit index = 5, snapshot = 0
  - an = 6'b111111, seg = 7'b1111111, dp = 1, frame_tick = 0
- Prescaler:
  - Counts 0..SCAN_DIV-1, then wraps to 0.
  - step = (prescaler == SCAN_DIV-1).
- On step:
  - Digit index advances 0→1→…→5→0.
  - When the index moves 5→0, sec/min/hour are copied into the snapshot registers and frame_tick = 1 for that single cycle.
  - Every other cycle, frame_tick = 0.
- First step after reset therefore starts a frame, lighting digit 0 from freshly captured inputs.
- Registered outputs:
  - an/seg/dp update on the same clock edge as the index change.
  - They reflect the new index and, for digit 0, the freshly captured snapshot.
  - Input→display latency: at most one frame plus one cycle.
- Digit map (index: value):
  - 0: sec ones; 1: sec tens
  - 2: min ones; 3: min tens
  - 4: hour ones; 5: hour tens
- Digit enable: an[index] = 0, all other an bits = 1.
- BCD conversion:
  - tens = value / 10 and ones = value % 10, via compare/subtract on the 6-bit value.
  - No divider.
- Segment codes (active-low gfedcba):
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000
  - dash=0111111
- Out-of-range fields: if a snapshot sec or min is >59, or hour is >23, both digits of that field show dash for the whole frame. Other fields are unaffected.
- dp:
  - Lit (0) on index 2 and index 4, forming the HH.MM.SS separators.
  - Index 5 is governed by the optional feature; all other digits = 1.
- Inputs change mid-frame: no effect until the next 5→0 transition.
- Reset asserted mid-scan: outputs go blank immediately. Scanning restarts per the reset description above.

Optional Feature:
- Macro: CLOCK_DISPLAY_HOUR12_EN.
- Defined (12-hour display):
  - Displayed hour = 12 if snapshot hour is 0 or 12.
  - hour-12 if hour is 13..23; otherwise hour.
  - PM indicator: dp on index 5 lit when hour ≥12 (and ≤23).
  - Out-of-range hour shows dashes with dp off.
- Undefined:
  - 24-hour display, hour shown unchanged.
  - dp on index 5 always 1.

Test Plan:
- Reset held, then released with SCAN_DIV=4:
  - During reset, an=111111, seg=1111111, dp=1.
  - First frame_tick occurs 4 cycles after release, with an=111110.
- hour=12, min=34, sec=59, SCAN_DIV=4, one full frame:
  - Index 0..5 gives seg 0010000, 0010010, 0011001, 0110000, 0100100, 1111001.
  - dp=0 only on index 2 and 4.
  - Each digit is held 4 cycles; frame_tick recurs every 24 cycles.
- Snapshot integrity: change sec 59→0 and min 34→35 while index=3:
  - Remainder of the frame still shows 34/59.
  - Next frame shows 35/00.
- sec=60, min=5, hour=7:
  - Index 0 and 1 show dash 0111111.
  - Index 2..5 show 5, 0, 7, 0.
- Reset asserted asynchronously mid-cycle while index=3:
  - Outputs blank immediately, without waiting for a clock edge.
  - After release, the first frame restarts at index 0 after SCAN_DIV cycles.
- With CLOCK_DISPLAY_HOUR12_EN:
  - hour=0 → digits "12", dp index5 = 1.
  - hour=13 → "01", dp index5 = 0.
  - hour=12 → "12", dp index5 = 0.
  - Without the macro, hour=13 → "13", dp index5 = 1.
